muldiv: RTL

MULDIV -- requirements
Module: muldiv

---
 rtl/muldiv_pkg.sv | 20 ++
 rtl/muldiv.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared encodings for the iterative multiply/divide unit
// Contents:
//   op_e    : operation select as presented on the muldiv op port
//   state_e : control FSM states
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MUL   = 2'b00,   // low half of the product
        OP_MULHU = 2'b01,   // high half of the unsigned product
        OP_DIVU  = 2'b10,   // unsigned quotient
        OP_REMU  = 2'b11    // unsigned remainder
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/muldiv.sv
// rtl/muldiv.sv - iterative unsigned multiply/divide unit with register-file write-back
// Ports:
//   clk     : clock, rising edge
//   rst     : asynchronous active-low reset
//   start   : request a new operation, sampled only while idle
//   op      : 00 MUL, 01 MULHU, 10 DIVU, 11 REMU
//   a, b    : operands from register file read ports
//   dest    : destination register address
//   busy    : operation in flight (from the cycle after accept through DONE)
//   done    : one-cycle completion pulse
//   wb_en   : register file write enable (suppressed for dest == 0)
//   wb_addr : register file write address
//   wb_data : register file write data
module muldiv
    import muldiv_pkg::*;
#(
    parameter int n = 32,
    parameter int r = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic [r-1:0] dest,
    output logic         busy,
    output logic         done,
    output logic         wb_en,
    output logic [r-1:0] wb_addr,
    output logic [n-1:0] wb_data
);

    localparam int CW = $clog2(n) + 1;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q;
    op_e            op_q;
    logic [r-1:0]   dest_q;
    logic [n-1:0]   b_q;

    // hi:lo is the 2n-bit working register shared by both algorithms.
    // Multiply: hi accumulates the partial product, lo holds the unconsumed
    // multiplier bits and fills with product low bits from the top.
    // Divide: hi is the partial remainder, lo shifts dividend bits out of the
    // top while quotient bits enter at the bottom.
    logic [n-1:0]   hi_q, lo_q;
    logic [n-1:0]   hi_d, lo_d;
    logic [n:0]     mul_sum;
    logic [n:0]     div_shift;
    logic [n-1:0]   div_diff;
    logic           is_div;
    logic [n-1:0]   result;

    assign is_div = (op_q == OP_DIVU) || (op_q == OP_REMU);

    // One iteration of shift-add multiply or restoring divide.
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(n+1){1'b0}});
        div_shift = {hi_q, lo_q[n-1]};
        // Only used when div_shift >= b, so the difference is below b and
        // the low n bits are exact.
        div_diff  = div_shift[n-1:0] - b_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        if (is_div) begin
            if (div_shift >= {1'b0, b_q}) begin
                hi_d = div_diff;
                lo_d = {lo_q[n-2:0], 1'b1};
            end else begin
                hi_d = div_shift[n-1:0];
                lo_d = {lo_q[n-2:0], 1'b0};
            end
        end else begin
            hi_d = mul_sum[n:1];
            lo_d = {mul_sum[0], lo_q[n-1:1]};
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; RUN lasts exactly n cycles because the counter is
    // loaded with n and the exit happens on the decrement that reaches zero.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN:  if (cnt_q == CW'(1)) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and captured operation
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            b_q    <= '0;
            op_q   <= OP_MUL;
            dest_q <= '0;
        end else if (state_q == ST_IDLE && start) begin
            cnt_q  <= CW'(n);
            hi_q   <= '0;
            lo_q   <= a;
            b_q    <= b;
            op_q   <= op_e'(op);
            dest_q <= dest;
        end else if (state_q == ST_RUN) begin
            cnt_q  <= cnt_q - CW'(1);
            hi_q   <= hi_d;
            lo_q   <= lo_d;
        end
    end

    // Divide by zero needs no special case: every trial subtract succeeds,
    // giving an all-ones quotient and a remainder equal to the dividend.
    assign result = (op_q == OP_MUL || op_q == OP_DIVU) ? lo_q : hi_q;

    // Outputs feed the register file write port directly.
    always_comb begin
        busy    = (state_q != ST_IDLE);
        done    = (state_q == ST_DONE);
        wb_en   = 1'b0;
        wb_addr = '0;
        wb_data = '0;
        if (state_q == ST_DONE) begin
            wb_en   = (dest_q != '0);
            wb_addr = dest_q;
            wb_data = result;
        end
    end

endmodule
